pci_mem_target: RTL and testbench



---
 rtl/pci_target_pkg.sv | 34 +++
 rtl/pci_target_mem.sv | 41 ++++
 rtl/pci_mem_target.sv | 141 ++++++++++++++
 tb/tb_pci_mem_target.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pci_target_pkg.sv
// ============================================================================
// pci_target_pkg: shared commands, FSM states and helpers for pci_mem_target
// Rev 1.0
// ============================================================================
`default_nettype none

package pci_target_pkg;

    localparam int DEPTH_DEFAULT = 8;

    localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_DATA = 3'd1,
        RD_TA   = 3'd2,
        RD_DATA = 3'd3,
        TERM    = 3'd4
    } state_t;

    // Expand active-low byte enables into a 32-bit data mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] be_n);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = be_n[b] ? 8'h00 : 8'hFF;
        end
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pci_target_mem.sv
// ============================================================================
// pci_target_mem: DEPTH x 32 storage, per-byte write, sync clear, async read
// Rev 1.0
// ============================================================================
`default_nettype none

module pci_target_mem
    import pci_target_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        byte_we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (byte_we[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

`default_nettype wire

// File: rtl/pci_mem_target.sv
// ============================================================================
// pci_mem_target: 32-bit PCI memory target; READ_BYTE_MASK_EN zeroes disabled
// read lanes.  Rev 1.0
// ============================================================================
`default_nettype none

module pci_mem_target
    import pci_target_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Frame,
    input  logic        IRDY,
    input  logic [3:0]  CBE,
    input  logic        oe,
    inout  wire  [31:0] AddressDataLine,
    output logic        DEVSEL,
    output logic        TRDY
);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] next_ptr;
    logic              ignore;
    logic              next_ignore;
    logic              wr_en;
    logic              drive_ad;
    logic              addr_hit;
    logic              mem_clear;
    logic [3:0]        byte_we;
    logic [31:0]       mem_word;
    logic [31:0]       rd_word;

    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + ADDR_W'(1);
    endfunction

    assign addr_hit = (AddressDataLine < 32'(DEPTH));

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state  <= IDLE;
            ptr    <= '0;
            ignore <= 1'b0;
        end else begin
            state  <= next_state;
            ptr    <= next_ptr;
            ignore <= next_ignore;
        end
    end

    // TERM behaves like IDLE for decode so a new address phase is taken right away.
    always_comb begin
        next_state  = state;
        next_ptr    = ptr;
        next_ignore = ignore;
        wr_en       = 1'b0;
        drive_ad    = 1'b0;
        DEVSEL      = 1'b1;
        TRDY        = 1'b1;
        case (state)
            IDLE, TERM: begin
                next_state = IDLE;
                if (ignore) begin
                    if (Frame && IRDY) begin
                        next_ignore = 1'b0;
                    end
                end else if (!Frame) begin
                    if (addr_hit && (CBE == CMD_MEM_WRITE)) begin
                        next_state = WR_DATA;
                        next_ptr   = AddressDataLine[ADDR_W-1:0];
                    end else if (addr_hit && (CBE == CMD_MEM_READ)) begin
                        next_state = RD_TA;
                        next_ptr   = AddressDataLine[ADDR_W-1:0];
                    end else begin
                        next_ignore = 1'b1;
                    end
                end
            end
            WR_DATA: begin
                DEVSEL = 1'b0;
                TRDY   = 1'b0;
                if (!IRDY) begin
                    wr_en    = 1'b1;
                    next_ptr = ptr_inc(ptr);
                    if (Frame) begin
                        next_state = TERM;
                    end
                end
            end
            RD_TA: begin
                DEVSEL     = 1'b0;
                next_state = RD_DATA;
            end
            RD_DATA: begin
                DEVSEL   = 1'b0;
                TRDY     = 1'b0;
                drive_ad = !oe;
                if (!IRDY) begin
                    next_ptr = ptr_inc(ptr);
                    if (Frame) begin
                        next_state = TERM;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign mem_clear = !Rst;
    assign byte_we   = wr_en ? ~CBE : 4'b0000;

    pci_target_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (Clk),
        .clear   (mem_clear),
        .addr    (ptr),
        .byte_we (byte_we),
        .wdata   (AddressDataLine),
        .rdata   (mem_word)
    );

`ifdef READ_BYTE_MASK_EN
    assign rd_word = mem_word & byte_mask(CBE);
`else
    assign rd_word = mem_word;
`endif

    assign AddressDataLine = drive_ad ? rd_word : 32'bz;

endmodule

`default_nettype wire

// File: tb/tb_pci_mem_target.sv
// ============================================================================
// tb_pci_mem_target: directed self-checking bench for pci_mem_target
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pci_mem_target;
    import pci_target_pkg::*;

    logic        Clk;
    logic        Rst;
    logic        Frame;
    logic        IRDY;
    logic        oe;
    logic [3:0]  CBE;
    logic [31:0] tb_ad;
    wire  [31:0] ad_bus;
    logic        DEVSEL;
    logic        TRDY;

    int total;
    int bad;

    logic [31:0] wd    [16];
    logic [3:0]  wbe   [16];
    logic        wdev  [16];
    logic        wtrdy [16];
    logic [31:0] rdat  [16];
    logic        rdev  [16];
    logic        rtrdy [16];

    assign ad_bus = oe ? tb_ad : 32'bz;

    pci_mem_target dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .Frame           (Frame),
        .IRDY            (IRDY),
        .CBE             (CBE),
        .oe              (oe),
        .AddressDataLine (ad_bus),
        .DEVSEL          (DEVSEL),
        .TRDY            (TRDY)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Nothing on the bus shows as Z, or as 0 where tristates collapse.
    function automatic bit released(input logic [31:0] v);
        return (v === 32'hzzzzzzzz) || (v === 32'h00000000);
    endfunction

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic bus_idle;
        Frame = 1'b1;
        IRDY  = 1'b1;
        oe    = 1'b0;
        CBE   = 4'hF;
        tb_ad = 32'h0;
    endtask

    task automatic wr_burst(input logic [31:0] addr, input int n);
        Frame = 1'b0; IRDY = 1'b1; oe = 1'b1; CBE = CMD_MEM_WRITE; tb_ad = addr;
        tick();
        for (int i = 0; i < n; i++) begin
            IRDY  = 1'b0;
            CBE   = wbe[i];
            tb_ad = wd[i];
            Frame = (i == n - 1);
            @(negedge Clk);
            wdev[i]  = DEVSEL;
            wtrdy[i] = TRDY;
            tick();
        end
        bus_idle();
    endtask

    task automatic rd_burst(input logic [31:0] addr, input int n);
        Frame = 1'b0; IRDY = 1'b1; oe = 1'b1; CBE = CMD_MEM_READ; tb_ad = addr;
        tick();
        oe = 1'b0; IRDY = 1'b0; CBE = 4'h0;
        tick();
        for (int i = 0; i < n; i++) begin
            Frame = (i == n - 1);
            @(negedge Clk);
            rdat[i]  = ad_bus;
            rdev[i]  = DEVSEL;
            rtrdy[i] = TRDY;
            tick();
        end
        bus_idle();
    endtask

    task automatic test_reset;
        Rst = 1'b0;
        bus_idle();
        tick();
        tick();
        @(negedge Clk);
        total++; if (DEVSEL !== 1'b1) begin bad++; $display("FAIL reset_devsel: got %b want 1", DEVSEL); end
        total++; if (TRDY !== 1'b1) begin bad++; $display("FAIL reset_trdy: got %b want 1", TRDY); end
        total++; if (!released(ad_bus)) begin bad++; $display("FAIL reset_ad: got %h want released", ad_bus); end
        Rst = 1'b1;
        tick();
    endtask

    task automatic test_byte_mask_write;
        logic [31:0] exp [4];
        wd[0] = 32'h12345678; wbe[0] = 4'b0011;
        wd[1] = 32'h33345633; wbe[1] = 4'b1001;
        wd[2] = 32'h44442222; wbe[2] = 4'b1100;
        wd[3] = 32'h55555555; wbe[3] = 4'b1111;
        wr_burst(32'd0, 4);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (wdev[i] !== 1'b0 || wtrdy[i] !== 1'b0) begin
                bad++; $display("FAIL wr_handshake[%0d]: got devsel=%b trdy=%b want 0 0", i, wdev[i], wtrdy[i]);
            end
        end
        exp[0] = 32'h12340000; exp[1] = 32'h00345600; exp[2] = 32'h00002222; exp[3] = 32'h00000000;
        rd_burst(32'd0, 4);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rdat[i] !== exp[i]) begin
                bad++; $display("FAIL masked_rd[%0d]: got %h want %h", i, rdat[i], exp[i]);
            end
        end
    endtask

    task automatic test_full_enable_write;
        logic [31:0] exp [3];
        wd[0] = 32'h12345123; wbe[0] = 4'b0110;
        wd[1] = 32'h33337746; wbe[1] = 4'b1111;
        wd[2] = 32'h44442222; wbe[2] = 4'b1100;
        wr_burst(32'd3, 3);
        // CBE=0110 enables lanes 3 and 0.
        exp[0] = 32'h12000023; exp[1] = 32'h00000000; exp[2] = 32'h00002222;
        rd_burst(32'd3, 3);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rdat[i] !== exp[i]) begin
                bad++; $display("FAIL addr3_rd[%0d]: got %h want %h", i, rdat[i], exp[i]);
            end
        end
    endtask

    task automatic test_read_timing;
        Frame = 1'b0; IRDY = 1'b1; oe = 1'b1; CBE = CMD_MEM_READ; tb_ad = 32'd0;
        @(negedge Clk);
        total++; if (DEVSEL !== 1'b1) begin bad++; $display("FAIL rt_addr_devsel: got %b want 1", DEVSEL); end
        tick();
        oe = 1'b0; IRDY = 1'b0; CBE = 4'h0;
        @(negedge Clk);
        total++; if (DEVSEL !== 1'b0) begin bad++; $display("FAIL rt_ta_devsel: got %b want 0", DEVSEL); end
        total++; if (TRDY !== 1'b1) begin bad++; $display("FAIL rt_ta_trdy: got %b want 1", TRDY); end
        total++; if (!released(ad_bus)) begin bad++; $display("FAIL rt_ta_ad: got %h want released", ad_bus); end
        tick();
        @(negedge Clk);
        total++; if (TRDY !== 1'b0) begin bad++; $display("FAIL rt_d0_trdy: got %b want 0", TRDY); end
        total++; if (ad_bus !== 32'h12340000) begin bad++; $display("FAIL rt_d0_ad: got %h want 12340000", ad_bus); end
        tick();
        Frame = 1'b1;
        @(negedge Clk);
        total++; if (ad_bus !== 32'h00345600) begin bad++; $display("FAIL rt_d1_ad: got %h want 00345600", ad_bus); end
        tick();
        bus_idle();
        @(negedge Clk);
        total++; if (DEVSEL !== 1'b1 || TRDY !== 1'b1) begin bad++; $display("FAIL rt_end_ctl: got devsel=%b trdy=%b want 1 1", DEVSEL, TRDY); end
        total++; if (!released(ad_bus)) begin bad++; $display("FAIL rt_end_ad: got %h want released", ad_bus); end
        tick();
    endtask

    task automatic test_wrap;
        logic [31:0] exp [8];
        for (int i = 0; i < 6; i++) begin
            wd[i]  = 32'hC0DE0000 + 32'(i);
            wbe[i] = 4'b0000;
        end
        wr_burst(32'd5, 6);
        // Read 8 words from 5: 5,6,7,0,1,2,3,4
        exp[0] = 32'hC0DE0000; exp[1] = 32'hC0DE0001; exp[2] = 32'hC0DE0002;
        exp[3] = 32'hC0DE0003; exp[4] = 32'hC0DE0004; exp[5] = 32'hC0DE0005;
        exp[6] = 32'h12000023; exp[7] = 32'h00000000;
        rd_burst(32'd5, 8);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (rdat[i] !== exp[i]) begin
                bad++; $display("FAIL wrap_rd[%0d]: got %h want %h", i, rdat[i], exp[i]);
            end
        end
    endtask

    task automatic test_wait_states;
        Frame = 1'b0; IRDY = 1'b1; oe = 1'b1; CBE = CMD_MEM_READ; tb_ad = 32'd0;
        tick();
        oe = 1'b0; IRDY = 1'b0; CBE = 4'h0;
        tick();
        @(negedge Clk);
        total++; if (ad_bus !== 32'hC0DE0003) begin bad++; $display("FAIL wait_d0: got %h want C0DE0003", ad_bus); end
        tick();
        IRDY = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            total++;
            if (ad_bus !== 32'hC0DE0004 || TRDY !== 1'b0) begin
                bad++; $display("FAIL wait_hold[%0d]: got ad=%h trdy=%b want C0DE0004 0", i, ad_bus, TRDY);
            end
            tick();
        end
        IRDY = 1'b0;
        @(negedge Clk);
        total++; if (ad_bus !== 32'hC0DE0004) begin bad++; $display("FAIL wait_resume: got %h want C0DE0004", ad_bus); end
        tick();
        Frame = 1'b1;
        @(negedge Clk);
        total++; if (ad_bus !== 32'hC0DE0005) begin bad++; $display("FAIL wait_next: got %h want C0DE0005", ad_bus); end
        tick();
        bus_idle();
        @(negedge Clk);
        total++; if (DEVSEL !== 1'b1) begin bad++; $display("FAIL wait_end_devsel: got %b want 1", DEVSEL); end
        tick();
    endtask

    task automatic test_no_claim;
        logic [31:0] addr_v [2];
        logic [3:0]  cmd_v  [2];
        logic [31:0] exp    [3];
        addr_v[0] = 32'd1; cmd_v[0] = 4'b0010;
        addr_v[1] = 32'd8; cmd_v[1] = CMD_MEM_WRITE;
        for (int c = 0; c < 2; c++) begin
            Frame = 1'b0; IRDY = 1'b1; oe = 1'b1; CBE = cmd_v[c]; tb_ad = addr_v[c];
            tick();
            // Data phases that look like a fresh write address phase.
            for (int i = 0; i < 3; i++) begin
                IRDY = 1'b0; CBE = CMD_MEM_WRITE; tb_ad = 32'd2; Frame = (i == 2);
                @(negedge Clk);
                total++;
                if (DEVSEL !== 1'b1 || TRDY !== 1'b1) begin
                    bad++; $display("FAIL noclaim%0d_ctl[%0d]: got devsel=%b trdy=%b want 1 1", c, i, DEVSEL, TRDY);
                end
                tick();
            end
            bus_idle();
            @(negedge Clk);
            total++; if (!released(ad_bus)) begin bad++; $display("FAIL noclaim%0d_ad: got %h want released", c, ad_bus); end
            tick();
        end
        exp[0] = 32'hC0DE0003; exp[1] = 32'hC0DE0004; exp[2] = 32'hC0DE0005;
        rd_burst(32'd0, 3);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rdat[i] !== exp[i]) begin
                bad++; $display("FAIL noclaim_mem[%0d]: got %h want %h", i, rdat[i], exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        wd[0] = 32'hDEADBEEF; wbe[0] = 4'b0000;
        wr_burst(32'd6, 1);
        rd_burst(32'd6, 1);
        total++; if (rdev[0] !== 1'b0 || rtrdy[0] !== 1'b0) begin bad++; $display("FAIL b2b_ctl: got devsel=%b trdy=%b want 0 0", rdev[0], rtrdy[0]); end
        total++; if (rdat[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL b2b_data: got %h want DEADBEEF", rdat[0]); end
    endtask

    task automatic test_reset_mid;
        Frame = 1'b0; IRDY = 1'b1; oe = 1'b1; CBE = CMD_MEM_WRITE; tb_ad = 32'd0;
        tick();
        IRDY = 1'b0; CBE = 4'h0; tb_ad = 32'hFFFFFFFF;
        tick();
        Rst = 1'b0; tb_ad = 32'hEEEEEEEE;
        tick();
        Rst = 1'b1;
        bus_idle();
        @(negedge Clk);
        total++; if (DEVSEL !== 1'b1 || TRDY !== 1'b1) begin bad++; $display("FAIL rstmid_ctl: got devsel=%b trdy=%b want 1 1", DEVSEL, TRDY); end
        tick();
        rd_burst(32'd0, 8);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (rdat[i] !== 32'h0) begin
                bad++; $display("FAIL rstmid_mem[%0d]: got %h want 00000000", i, rdat[i]);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Rst   = 1'b0;
        bus_idle();
        test_reset();
        test_byte_mask_write();
        test_full_enable_write();
        test_read_timing();
        test_wrap();
        test_wait_states();
        test_no_claim();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
